// File: rtl/cla_multiword_add_seq_if.sv
// Valid/ready request and result bundle for the multi-word add/sub sequencer.
// The operand and result width is W*K bits.
interface cla_multiword_add_seq_if #(
  parameter int W = 16,
  parameter int K = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W*K-1:0]   a;
  logic [W*K-1:0]   b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [W*K-1:0]   sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_multiword_add_seq.sv
// W*K-bit add/subtract built from one W-bit carry-look-ahead slice reused over K cycles,
// processing the least-significant chunk first and holding the inter-chunk carry in a register.
module cla_multiword_add_seq #(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cla_multiword_add_seq_if.slave  bus
);
  localparam int N  = W * K;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [KW-1:0]   k_r;
  logic            carry_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [N-1:0]    sum_r;
  logic            cout_r;
  logic            ovf_r;
  logic [W-1:0]    a_chunk_s;
  logic [W-1:0]    b_chunk_s;
  logic [W:0]      slice_s;
  logic            last_s;

  // Look-ahead slice: every carry is a flat sum-of-products of generate/propagate terms.
  function automatic logic [W:0] cla_slice(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c0);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < W; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = g[i] | term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[W], p ^ c[W-1:0]};
  endfunction

  assign a_chunk_s = a_r[int'(k_r)*W +: W];
  assign b_chunk_s = b_r[int'(k_r)*W +: W];
  assign slice_s   = cla_slice(a_chunk_s, b_chunk_s, carry_r);
  assign last_s    = (k_r == KW'(K - 1));

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_s = RUN;
        else              state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            // Subtract is a + ~b + 1, so the inverted operand and forced carry are latched here.
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            k_r     <= '0;
          end
        end
        RUN: begin
          sum_r[int'(k_r)*W +: W] <= slice_s[W-1:0];
          carry_r                 <= slice_s[W];
          k_r                     <= k_r + KW'(1);
          if (last_s) begin
            cout_r <= slice_s[W];
            ovf_r  <= (a_r[N-1] == b_r[N-1]) && (slice_s[W-1] != a_r[N-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Directed bench for cla_multiword_add_seq with W=16, K=4.
module tb_cla_multiword_add_seq;
  localparam int W = 16;
  localparam int K = 4;
  localparam int N = W * K;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cla_multiword_add_seq_if #(.W(W), .K(K)) bus ();

  cla_multiword_add_seq #(.W(W), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic cv, input logic sv, output int lat);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.cin = cv; bus.sub = sv;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic xfer();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.sum !== 64'h0) begin bad++; $display("FAIL rst_sum got=%h want=0", bus.sum); end
    total++; if ({bus.cout, bus.ovf} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {bus.cout, bus.ovf}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_arith();
    logic [N-1:0] ta [5];
    logic [N-1:0] tb [5];
    logic         tc [5];
    logic         ts [5];
    logic [N-1:0] es [5];
    logic [1:0]   ef [5];
    int           lat;
    ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'h0;  tc[0] = 1'b1; ts[0] = 1'b0;
    es[0] = 64'h0000_0000_0001_0000; ef[0] = 2'b00;
    ta[1] = 64'd5; tb[1] = 64'd7; tc[1] = 1'b1; ts[1] = 1'b1;
    es[1] = 64'hFFFF_FFFF_FFFF_FFFE; ef[1] = 2'b00;
    ta[2] = 64'd7; tb[2] = 64'd5; tc[2] = 1'b0; ts[2] = 1'b1;
    es[2] = 64'd2; ef[2] = 2'b10;
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'd1; tc[3] = 1'b0; ts[3] = 1'b0;
    es[3] = 64'h8000_0000_0000_0000; ef[3] = 2'b01;
    ta[4] = 64'h8000_0000_0000_0000; tb[4] = 64'd1; tc[4] = 1'b0; ts[4] = 1'b1;
    es[4] = 64'h7FFF_FFFF_FFFF_FFFF; ef[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], ts[i], lat);
      total++; if (lat !== K) begin bad++; $display("FAIL arith%0d_latency got=%0d want=%0d", i, lat, K); end
      total++; if (bus.sum !== es[i]) begin bad++; $display("FAIL arith%0d_sum got=%h want=%h", i, bus.sum, es[i]); end
      total++; if ({bus.cout, bus.ovf} !== ef[i]) begin bad++; $display("FAIL arith%0d_cout_ovf got=%b want=%b", i, {bus.cout, bus.ovf}, ef[i]); end
      xfer();
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL arith%0d_in_ready got=%b want=1", i, bus.in_ready); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int first_ov;
    logic [N-1:0] s0;
    logic         c0;
    logic         o0;
    first_ov = -1;
    s0 = '1; c0 = 1'b0; o0 = 1'b1;
    @(negedge clk);
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'd1; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    // Index c is the negedge just before edge c; state seen here decides what edge c does.
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 7) bus.in_valid = 1'b0;
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) acc.push_back(c);
      if (bus.out_valid === 1'b1 && first_ov < 0) begin
        first_ov = c;
        s0 = bus.sum; c0 = bus.cout; o0 = bus.ovf;
      end
    end
    bus.out_ready = 1'b0;
    total++; if (acc.size() !== 2) begin bad++; $display("FAIL b2b_accept_count got=%0d want=2", acc.size()); end
    if (acc.size() == 2) begin
      total++; if (acc[1] - acc[0] !== K + 2) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", acc[1] - acc[0], K + 2); end
    end
    // out_valid first seen after edge acc0+K, i.e. at index acc0+K+1.
    total++; if (first_ov !== K + 1) begin bad++; $display("FAIL b2b_out_valid_rise got=%0d want=%0d", first_ov, K + 1); end
    total++; if (s0 !== 64'h0) begin bad++; $display("FAIL b2b_sum got=%h want=0", s0); end
    total++; if ({c0, o0} !== 2'b10) begin bad++; $display("FAIL b2b_cout_ovf got=%b want=10", {c0, o0}); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b want=0", bus.busy); end
  endtask

  task automatic test_hold();
    int lat;
    logic [N-1:0] exp_sum;
    exp_sum = 64'h1234_5678_9ABC_DF00;
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.sub = bus.in_valid;
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== exp_sum ||
          bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d got ov=%b ir=%b sum=%h c=%b o=%b want ov=1 ir=0 sum=%h c=0 o=0",
                 i, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf, exp_sum);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid); end
    total++; if (bus.sum !== exp_sum) begin bad++; $display("FAIL hold_sum_kept got=%h want=%h", bus.sum, exp_sum); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    @(negedge clk);
    bus.a = 64'h1234_5678_9ABC_DEF0; bus.b = 64'd1; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got ov=%b busy=%b want 0 0", bus.out_valid, bus.busy); end
    total++; if (bus.sum !== 64'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin bad++; $display("FAIL midrst_data got sum=%h c=%b o=%b want 0", bus.sum, bus.cout, bus.ovf); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
    repeat (6) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result got=%b want=0", bus.out_valid); end
    run_op(64'h0000_0001_0000_0003, 64'h0000_0002_0000_FFFF, 1'b0, 1'b0, lat);
    total++; if (lat !== K) begin bad++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, K); end
    total++; if (bus.sum !== 64'h0000_0003_0001_0002) begin bad++; $display("FAIL midrst_next_sum got=%h want=0000000300010002", bus.sum); end
    xfer();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_hold();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_multiword_add_seq.md
Name: cla_multiword_add_seq

Overview:
Multi-cycle sequencer that performs an N = W*K bit add or subtract by reusing a single W-bit carry-look-ahead adder slice over K cycles, one chunk per cycle, least-significant chunk first.
- The chunk-to-chunk carry is held in a register.
- The block sits between a valid/ready producer and consumer.
- It trades latency for area, so wide arithmetic does not need a full N-bit look-ahead adder.

Parameters:
W, 16, adder slice width in bits (>=1)
K, 4, number of chunks per operation (>=1); operand width N = W*K

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
a  in  N  operand A
b  in  N  operand B
cin  in  1  carry in (add only; ignored when sub=1)
sub  in  1  1 = compute a-b, 0 = compute a+b+cin
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
sum  out  N  result
cout  out  1  final carry out (for sub: 1 = no borrow)
ovf  out  1  two's-complement signed overflow
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, chunk index=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- in_ready = (state==IDLE); out_valid = (state==DONE); both are combinational from state.
- IDLE: on an edge with in_valid=1:
  - latch A=a;
  - latch B'=sub ? ~b : b;
  - carry reg = sub ? 1 : cin;
  - chunk index=0; go to RUN.
  - in_valid=0 keeps the block in IDLE.
- RUN: each cycle, slice computes {c, s} = A[k*W +: W] + B'[k*W +: W] + carry reg. On the edge:
  - sum[k*W +: W] = s;
  - carry reg = c;
  - k = k+1.
- When k==K-1, that edge also:
  - sets cout = c;
  - sets ovf = (A[N-1]==B'[N-1]) && (s[W-1]!=A[N-1]);
  - goes to DONE.
- DONE: sum, cout and ovf are held stable. Transfer occurs on an edge with out_ready=1, then go to IDLE. out_ready=0 holds DONE indefinitely.
- Latency: out_valid rises exactly K cycles after the accepting edge.
- Minimum request-to-request period is K+2 cycles: accept edge, K RUN edges, transfer edge, then one IDLE cycle.
- sum contents are only defined while out_valid=1; the verifier must not check sum during RUN. In IDLE after a transfer, sum/cout/ovf keep their last values until the next accept.
- in_valid is ignored outside IDLE; no request is queued.
- Operands are captured at accept; input changes during RUN or DONE have no effect.
- K=1: a single RUN cycle, then DONE.
- All arithmetic is modulo 2^N. Subtract is a + ~b + 1; cin is ignored in subtract mode.
- rst asserted in RUN or DONE aborts the operation. No out_valid is produced for the aborted request.

Test Plan:
(W=16, K=4, N=64)
1. Assert rst mid-RUN -> out_valid=0, busy=0, sum=0, cout=0, ovf=0 immediately (async); in_ready=1 after release; the next request completes normally.
2. Add a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, out_ready=1 -> sum=0, cout=1, ovf=0. out_valid high exactly 4 cycles after the accept edge; next accept is possible 6 cycles after the first.
3. Add a=0x0000_0000_0000_FFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000, cout=0. This checks the carry crossing the chunk boundary.
4. Subtract a=5, b=7, sub=1, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5 -> sum=2, cout=1.
5. Add a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. Subtract a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
6. Hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b -> out_valid=1, sum/cout/ovf stable, in_ready=0, no new operation accepted. When out_ready=1, the transfer completes and in_ready=1 on the following cycle.
